wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; only 32 is supported.
REQ-002 Parameter CNT_W, default 32, width of the retire counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  hold the WB register contents.
REQ-006 flush  input  1  invalidate the WB register.
REQ-007 mem_valid  input  1  MEM stage holds a real instruction.
REQ-008 mem_regwrite  input  1  instruction writes rd.
REQ-009 mem_rd  input  5  destination register index.
REQ-010 mem_wdsel  input  2  write-data source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-011 mem_funct3  input  3  load width/sign code.
REQ-012 mem_alu_res  input  32  ALU result or load address.
REQ-013 mem_rdata  input  32  raw word read from data memory at the word-aligned address.
REQ-014 mem_pc4  input  32  PC+4 of the instruction.
REQ-015 mem_inst  input  32  instruction word, kept for trace.
REQ-016 RFWr  output  1  register-file write enable.
REQ-017 A3  output  5  register-file write index.
REQ-018 WD  output  32  register-file write data.
REQ-019 inst  output  32  instruction word in WB.
REQ-020 fwd_valid, fwd_rd[4:0], fwd_data[31:0]  output  forwarding source for EX; fwd_valid equals RFWr, fwd_rd equals A3, fwd_data equals WD.
REQ-021 load_err  output  1  registered misaligned or illegal load in WB.
REQ-022 retire_cnt  output  CNT_W  count of valid instructions captured into WB.

Function
REQ-023 Update priority on each rising edge SHALL be rst, then flush, then stall, then capture.
REQ-024 Flush SHALL clear the valid bit only; A3, WD and inst hold their previous values.
REQ-025 Stall SHALL hold every register, including retire_cnt.
REQ-026 Capture SHALL load valid <= mem_valid, A3 <= mem_rd, inst <= mem_inst, and the WD and load_err values computed from the current MEM inputs.
REQ-027 Latency SHALL be exactly one cycle from MEM inputs to registered outputs; outputs have no combinational path from inputs.
REQ-028 RFWr SHALL equal valid & regwrite & (A3 != 0) & !load_err.
REQ-029 RFWr SHALL stay asserted across stall cycles; the repeated write of the same value is idempotent by design.
REQ-030 Write-data selection SHALL be:
- mem_wdsel 00: WD = mem_alu_res.
- mem_wdsel 01: WD = extended load data.
- mem_wdsel 10: WD = mem_pc4.
- mem_wdsel 11: WD = 0 and load_err = 1.
REQ-031 Byte offset SHALL be mem_alu_res[1:0].
- LB (000) and LBU (100) select byte [8*off+7 : 8*off].
- LH (001) and LHU (101) select halfword [16*off[1]+15 : 16*off[1]].
- LW (010) selects the whole word.
- LB and LH sign-extend; LBU and LHU zero-extend.
REQ-032 Misaligned loads (LH/LHU with off[0]=1, LW with off!=0) and funct3 011, 110 or 111 with wdsel 01 SHALL set load_err = 1 and WD = 0.
REQ-033 load_err SHALL be evaluated only when wdsel is 01 or 11; otherwise load_err is captured as 0.
REQ-034 retire_cnt SHALL increment by 1 on each capture with mem_valid = 1, wrapping from all-ones to 0.
REQ-035 Simultaneous flush and stall SHALL flush; retire_cnt SHALL not increment on flush.

Reset
REQ-036 Synchronous rst SHALL clear valid, RFWr, A3, WD, inst, load_err and retire_cnt to 0, overriding a concurrent stall or flush.
REQ-037 rst asserted mid-stall SHALL discard the held instruction; the first capture occurs on the first edge after rst deasserts with stall = 0.

Structure
REQ-038 Shared package wb_pkg SHALL hold the WDSEL_* codes, the LD_* funct3 codes and the XLEN constant.
REQ-039 Alignment and extension SHALL be a combinational sub-module named load_ext (inputs rdata, off, funct3; outputs data, err).

Verification
REQ-040 LB at off 3 with rdata 0x80FF_1234, rd 5 -> next cycle RFWr=1, A3=5, WD=0xFFFF_FF80.
REQ-041 LHU at off 2 with rdata 0x8001_0000 -> WD=0x0000_8001; LH at off 1 -> load_err=1, RFWr=0, WD=0.
REQ-042 JAL with wdsel 10, pc4 0x0000_0104, rd 1 -> WD=0x104, RFWr=1; the same instruction with rd 0 -> RFWr=0.
REQ-043 Capture an ALU op (0x1234, rd 7), then stall 3 cycles, then flush -> outputs hold for 3 cycles, retire_cnt +1 only, then RFWr=0.
REQ-044 Preload retire_cnt to 0xFFFF_FFFF, capture a valid instruction -> retire_cnt = 0; assert rst with stall = 1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
// Holds the write-data source codes, the load funct3 codes, the datapath
// width and the layout of the WB pipeline register.
package wb_pkg;

    localparam int unsigned XLEN = 32;

    // Write-data source select.
    localparam logic [1:0] WDSEL_ALU  = 2'b00;
    localparam logic [1:0] WDSEL_LOAD = 2'b01;
    localparam logic [1:0] WDSEL_PC4  = 2'b10;
    localparam logic [1:0] WDSEL_RSVD = 2'b11;

    // Load width/sign codes (funct3).
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Contents of the WB pipeline register (retire counter kept separately).
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] inst;
        logic            load_err;
    } wb_reg_t;

    function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic sext);
        return {{(XLEN-8){sext & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic sext);
        return {{(XLEN-16){sext & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load alignment and extension.
// Picks the addressed byte/halfword/word out of the raw memory word and
// sign- or zero-extends it. Flags misaligned or undefined loads.
// Ports:
//   rdata  - raw 32-bit word read at the word-aligned address
//   off    - byte offset within the word
//   funct3 - load width/sign code
//   data   - extended load data (0 when err)
//   err    - misaligned access or undefined funct3
module load_ext (
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        err
);
    import wb_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            LD_LB, LD_LBU: begin
                // funct3[2] distinguishes the unsigned variants
                data = ext_byte(byte_sel, ~funct3[2]);
            end
            LD_LH, LD_LHU: begin
                if (off[0]) begin
                    err = 1'b1;
                end else begin
                    data = ext_half(half_sel, ~funct3[2]);
                end
            end
            LD_LW: begin
                if (off != 2'd0) begin
                    err = 1'b1;
                end else begin
                    data = rdata;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage.
// Registers the MEM-stage result, selects the register-file write data
// (ALU, extended load, PC+4), flags bad loads and counts retired
// instructions. All outputs come from registers (one-cycle latency).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   stall, flush         - hold / invalidate the WB register (flush wins)
//   mem_*                - MEM-stage instruction fields and data
//   RFWr, A3, WD         - register-file write port
//   inst                 - instruction word held in WB
//   fwd_valid/rd/data    - forwarding copy of the write port for EX
//   load_err             - misaligned or illegal load captured into WB
//   retire_cnt           - valid instructions captured, wraps
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wdsel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_res,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  mem_pc4,
    input  logic [XLEN-1:0]  mem_inst,
    output logic             RFWr,
    output logic [4:0]       A3,
    output logic [XLEN-1:0]  WD,
    output logic [XLEN-1:0]  inst,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             load_err,
    output logic [CNT_W-1:0] retire_cnt
);
    import wb_pkg::*;

    logic [XLEN-1:0] ld_data;
    logic            ld_err;
    logic [XLEN-1:0] cap_wd;
    logic            cap_err;

    wb_reg_t         wb_d, wb_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    load_ext u_load_ext (
        .rdata  (mem_rdata),
        .off    (mem_alu_res[1:0]),
        .funct3 (mem_funct3),
        .data   (ld_data),
        .err    (ld_err)
    );

    // Write-data select; load_err only meaningful for the load and reserved codes.
    always_comb begin
        cap_wd  = '0;
        cap_err = 1'b0;
        unique case (mem_wdsel)
            WDSEL_ALU:  cap_wd = mem_alu_res;
            WDSEL_LOAD: begin
                cap_wd  = ld_data;
                cap_err = ld_err;
            end
            WDSEL_PC4:  cap_wd = mem_pc4;
            default:    cap_err = 1'b1;
        endcase
    end

    // Priority below rst: flush, then stall, then capture.
    always_comb begin
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (flush) begin
            // Only the valid bit drops; data fields keep their old contents.
            wb_d.valid = 1'b0;
        end else if (!stall) begin
            wb_d.valid    = mem_valid;
            wb_d.regwrite = mem_regwrite;
            wb_d.rd       = mem_rd;
            wb_d.wd       = cap_wd;
            wb_d.inst     = mem_inst;
            wb_d.load_err = cap_err;
            if (mem_valid) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        RFWr       = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0) & ~wb_q.load_err;
        A3         = wb_q.rd;
        WD         = wb_q.wd;
        inst       = wb_q.inst;
        load_err   = wb_q.load_err;
        retire_cnt = cnt_q;
        fwd_valid  = RFWr;
        fwd_rd     = A3;
        fwd_data   = WD;
    end

endmodule
